// File: rtl/dac_pair_scheduler_if.sv
// Handshake bundle between the DSP sources, the pair scheduler and the DAC driver.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface dac_pair_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 14
);
    logic                  src_a_valid;
    logic [DATA_WIDTH-1:0] src_a_data;
    logic                  src_a_rdy;
    logic                  src_b_valid;
    logic [DATA_WIDTH-1:0] src_b_data;
    logic                  src_b_rdy;
    logic                  drv_valid;
    logic                  drv_channel;
    logic [DATA_WIDTH-1:0] drv_data;
    logic                  drv_rdy;

    modport master (
        input  src_a_valid,
        input  src_a_data,
        output src_a_rdy,
        input  src_b_valid,
        input  src_b_data,
        output src_b_rdy,
        output drv_valid,
        output drv_channel,
        output drv_data,
        input  drv_rdy
    );

    modport slave (
        output src_a_valid,
        output src_a_data,
        input  src_a_rdy,
        output src_b_valid,
        output src_b_data,
        input  src_b_rdy,
        input  drv_valid,
        input  drv_channel,
        input  drv_data,
        output drv_rdy
    );
endinterface

// File: rtl/dac_pair_scheduler.sv
// Sample-rate scheduler for the dual-channel DAC driver: divides clk down to a sample tick,
// buffers one sample per channel and emits an A-then-B word pair per tick.
module dac_pair_scheduler #(
    parameter int unsigned           DATA_WIDTH   = 14,
    parameter int unsigned           TICK_DIVIDER = 125,
    parameter logic [DATA_WIDTH-1:0] INIT_A       = '0,
    parameter logic [DATA_WIDTH-1:0] INIT_B       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    dac_pair_scheduler_if.master bus,
    output logic                 tick,
    output logic [7:0]           underrun_a,
    output logic [7:0]           underrun_b,
    output logic [15:0]          miss_cnt
);
    localparam int unsigned         DivWidth = $clog2(TICK_DIVIDER);
    localparam logic [DivWidth-1:0] DivLast  = DivWidth'(TICK_DIVIDER - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitRdy,
        StSendA,
        StSendB
    } state_e;

    state_e                state_q, state_d;
    logic [DivWidth-1:0]   div_q, div_d;
    logic                  tick_q, tick_d;

    logic                  full_a_q, full_a_d;
    logic                  full_b_q, full_b_d;
    logic [DATA_WIDTH-1:0] buf_a_q, buf_a_d;
    logic [DATA_WIDTH-1:0] buf_b_q, buf_b_d;
    logic [DATA_WIDTH-1:0] last_a_q, last_a_d;
    logic [DATA_WIDTH-1:0] last_b_q, last_b_d;

    logic                  drv_valid_q, drv_valid_d;
    logic                  drv_channel_q, drv_channel_d;
    logic [DATA_WIDTH-1:0] drv_data_q, drv_data_d;

    logic [7:0]            underrun_a_q, underrun_a_d;
    logic [7:0]            underrun_b_q, underrun_b_d;
    logic [15:0]           miss_q, miss_d;
    logic                  inc_ua, inc_ub, inc_miss;

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (!enable) begin
            div_d = '0;
        end else if (div_q == DivLast) begin
            div_d  = '0;
            tick_d = 1'b1;
        end else begin
            div_d = div_q + DivWidth'(1);
        end
    end

    // Outputs are computed for the state being entered so they leave the flops aligned with it.
    always_comb begin
        state_d       = state_q;
        full_a_d      = full_a_q;
        full_b_d      = full_b_q;
        buf_a_d       = buf_a_q;
        buf_b_d       = buf_b_q;
        last_a_d      = last_a_q;
        last_b_d      = last_b_q;
        drv_valid_d   = 1'b0;
        drv_channel_d = drv_channel_q;
        drv_data_d    = drv_data_q;
        inc_ua        = 1'b0;
        inc_ub        = 1'b0;
        inc_miss      = tick_q && (state_q != StIdle);

        // A load needs an empty buffer and a consume needs a full one, so they never collide.
        if (bus.src_a_valid && !full_a_q) begin
            full_a_d = 1'b1;
            buf_a_d  = bus.src_a_data;
        end
        if (bus.src_b_valid && !full_b_q) begin
            full_b_d = 1'b1;
            buf_b_d  = bus.src_b_data;
        end

        unique case (state_q)
            StIdle: begin
                if (tick_q) begin
                    state_d = StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (bus.drv_rdy) begin
                    state_d       = StSendA;
                    drv_valid_d   = 1'b1;
                    drv_channel_d = 1'b0;
                    if (full_a_q) begin
                        drv_data_d = buf_a_q;
                        last_a_d   = buf_a_q;
                        full_a_d   = 1'b0;
                    end else begin
                        drv_data_d = last_a_q;
                        inc_ua     = 1'b1;
                    end
                end
            end
            StSendA: begin
                state_d       = StSendB;
                drv_valid_d   = 1'b1;
                drv_channel_d = 1'b1;
                if (full_b_q) begin
                    drv_data_d = buf_b_q;
                    last_b_d   = buf_b_q;
                    full_b_d   = 1'b0;
                end else begin
                    drv_data_d = last_b_q;
                    inc_ub     = 1'b1;
                end
            end
            StSendB: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        underrun_a_d = underrun_a_q;
        underrun_b_d = underrun_b_q;
        miss_d       = miss_q;
        if (clear) begin
            underrun_a_d = '0;
            underrun_b_d = '0;
            miss_d       = '0;
        end else begin
            if (inc_ua && (underrun_a_q != '1)) begin
                underrun_a_d = underrun_a_q + 8'd1;
            end
            if (inc_ub && (underrun_b_q != '1)) begin
                underrun_b_d = underrun_b_q + 8'd1;
            end
            if (inc_miss && (miss_q != '1)) begin
                miss_d = miss_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            div_q         <= '0;
            tick_q        <= 1'b0;
            full_a_q      <= 1'b0;
            full_b_q      <= 1'b0;
            buf_a_q       <= '0;
            buf_b_q       <= '0;
            last_a_q      <= INIT_A;
            last_b_q      <= INIT_B;
            drv_valid_q   <= 1'b0;
            drv_channel_q <= 1'b0;
            drv_data_q    <= '0;
            underrun_a_q  <= '0;
            underrun_b_q  <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            tick_q        <= tick_d;
            full_a_q      <= full_a_d;
            full_b_q      <= full_b_d;
            buf_a_q       <= buf_a_d;
            buf_b_q       <= buf_b_d;
            last_a_q      <= last_a_d;
            last_b_q      <= last_b_d;
            drv_valid_q   <= drv_valid_d;
            drv_channel_q <= drv_channel_d;
            drv_data_q    <= drv_data_d;
            underrun_a_q  <= underrun_a_d;
            underrun_b_q  <= underrun_b_d;
            miss_q        <= miss_d;
        end
    end

    assign bus.src_a_rdy   = ~full_a_q;
    assign bus.src_b_rdy   = ~full_b_q;
    assign bus.drv_valid   = drv_valid_q;
    assign bus.drv_channel = drv_channel_q;
    assign bus.drv_data    = drv_data_q;
    assign tick            = tick_q;
    assign underrun_a      = underrun_a_q;
    assign underrun_b      = underrun_b_q;
    assign miss_cnt        = miss_q;
endmodule

// File: tb/tb_dac_pair_scheduler.sv
// Directed bench for dac_pair_scheduler: pair timing, underrun repeat, missed ticks,
// counter saturation and clear, reset mid-pair and enable gating.
module tb_dac_pair_scheduler;
    localparam int unsigned DW = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic        tick;
    logic [7:0]  underrun_a;
    logic [7:0]  underrun_b;
    logic [15:0] miss_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    dac_pair_scheduler_if #(.DATA_WIDTH(DW)) bus_if ();

    dac_pair_scheduler #(
        .DATA_WIDTH  (DW),
        .TICK_DIVIDER(125),
        .INIT_A      (14'h0),
        .INIT_B      (14'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .bus       (bus_if.master),
        .tick      (tick),
        .underrun_a(underrun_a),
        .underrun_b(underrun_b),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 300);
        chk("tick_seen", {31'b0, tick}, 32'd1);
    endtask

    task automatic load(input logic a_en, input logic [DW-1:0] a,
                        input logic b_en, input logic [DW-1:0] b);
        bus_if.src_a_valid = a_en;
        bus_if.src_a_data  = a;
        bus_if.src_b_valid = b_en;
        bus_if.src_b_data  = b;
        step();
        bus_if.src_a_valid = 1'b0;
        bus_if.src_b_valid = 1'b0;
    endtask

    // Called in the tick cycle; walks T+1..T+4.
    task automatic expect_pair(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        step();
        chk({tag, "_t1_valid"}, {31'b0, bus_if.drv_valid}, 32'd0);
        step();
        chk({tag, "_a_valid"}, {31'b0, bus_if.drv_valid}, 32'd1);
        chk({tag, "_a_ch"}, {31'b0, bus_if.drv_channel}, 32'd0);
        chk({tag, "_a_data"}, {18'b0, bus_if.drv_data}, {18'b0, a});
        step();
        chk({tag, "_b_valid"}, {31'b0, bus_if.drv_valid}, 32'd1);
        chk({tag, "_b_ch"}, {31'b0, bus_if.drv_channel}, 32'd1);
        chk({tag, "_b_data"}, {18'b0, bus_if.drv_data}, {18'b0, b});
        step();
        chk({tag, "_end_valid"}, {31'b0, bus_if.drv_valid}, 32'd0);
        chk({tag, "_hold_data"}, {18'b0, bus_if.drv_data}, {18'b0, b});
    endtask

    initial begin
        int n;
        int seen_tick;
        int seen_valid;

        reset              = 1'b1;
        enable             = 1'b0;
        clear              = 1'b0;
        bus_if.src_a_valid = 1'b0;
        bus_if.src_a_data  = '0;
        bus_if.src_b_valid = 1'b0;
        bus_if.src_b_data  = '0;
        bus_if.drv_rdy     = 1'b0;
        repeat (3) step();

        chk("rst_drv_valid", {31'b0, bus_if.drv_valid}, 32'd0);
        chk("rst_drv_ch", {31'b0, bus_if.drv_channel}, 32'd0);
        chk("rst_drv_data", {18'b0, bus_if.drv_data}, 32'd0);
        chk("rst_a_rdy", {31'b0, bus_if.src_a_rdy}, 32'd1);
        chk("rst_b_rdy", {31'b0, bus_if.src_b_rdy}, 32'd1);
        chk("rst_tick", {31'b0, tick}, 32'd0);
        chk("rst_ua", {24'b0, underrun_a}, 32'd0);
        chk("rst_ub", {24'b0, underrun_b}, 32'd0);
        chk("rst_miss", {16'b0, miss_cnt}, 32'd0);
        reset = 1'b0;
        step();

        // Preloaded pair
        load(1'b1, 14'h1234, 1'b1, 14'h0ABC);
        chk("t1_a_rdy_full", {31'b0, bus_if.src_a_rdy}, 32'd0);
        chk("t1_b_rdy_full", {31'b0, bus_if.src_b_rdy}, 32'd0);
        bus_if.drv_rdy = 1'b1;
        enable         = 1'b1;
        wait_tick(n);
        chk("t1_first_tick_cycles", n, 32'd125);
        expect_pair("t1", 14'h1234, 14'h0ABC);
        chk("t1_a_rdy_free", {31'b0, bus_if.src_a_rdy}, 32'd1);
        chk("t1_b_rdy_free", {31'b0, bus_if.src_b_rdy}, 32'd1);
        chk("t1_ua", {24'b0, underrun_a}, 32'd0);
        chk("t1_ub", {24'b0, underrun_b}, 32'd0);

        // Underrun repeats the last values
        wait_tick(n);
        chk("t2_tick_period", n, 32'd121);
        expect_pair("t2", 14'h1234, 14'h0ABC);
        chk("t2_ua", {24'b0, underrun_a}, 32'd1);
        chk("t2_ub", {24'b0, underrun_b}, 32'd1);

        load(1'b1, 14'h2222, 1'b0, 14'h0);
        chk("t2b_a_rdy", {31'b0, bus_if.src_a_rdy}, 32'd0);
        chk("t2b_b_rdy", {31'b0, bus_if.src_b_rdy}, 32'd1);
        wait_tick(n);
        expect_pair("t2b", 14'h2222, 14'h0ABC);
        chk("t2b_ua", {24'b0, underrun_a}, 32'd1);
        chk("t2b_ub", {24'b0, underrun_b}, 32'd2);

        // Driver busy across three ticks: first parks in WAIT_RDY, next two are missed
        bus_if.drv_rdy = 1'b0;
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        step();
        chk("t3_miss", {16'b0, miss_cnt}, 32'd2);
        chk("t3_no_valid", {31'b0, bus_if.drv_valid}, 32'd0);
        bus_if.drv_rdy = 1'b1;
        step();
        chk("t3_a_valid", {31'b0, bus_if.drv_valid}, 32'd1);
        chk("t3_a_ch", {31'b0, bus_if.drv_channel}, 32'd0);
        chk("t3_a_data", {18'b0, bus_if.drv_data}, 32'h2222);
        step();
        chk("t3_b_valid", {31'b0, bus_if.drv_valid}, 32'd1);
        chk("t3_b_ch", {31'b0, bus_if.drv_channel}, 32'd1);
        chk("t3_b_data", {18'b0, bus_if.drv_data}, 32'h0ABC);
        seen_valid = 0;
        repeat (20) begin
            step();
            if (bus_if.drv_valid === 1'b1) seen_valid++;
        end
        chk("t3_single_pair", seen_valid, 32'd0);
        chk("t3_ua", {24'b0, underrun_a}, 32'd2);
        chk("t3_ub", {24'b0, underrun_b}, 32'd3);

        // Saturation, then clear coinciding with an increment
        for (int i = 0; i < 300; i++) wait_tick(n);
        repeat (4) step();
        chk("t4_ua_sat", {24'b0, underrun_a}, 32'd255);
        chk("t4_ub_sat", {24'b0, underrun_b}, 32'd255);
        chk("t4_miss_hold", {16'b0, miss_cnt}, 32'd2);
        wait_tick(n);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t4_clear_ua", {24'b0, underrun_a}, 32'd0);
        chk("t4_clear_ub", {24'b0, underrun_b}, 32'd0);
        chk("t4_clear_miss", {16'b0, miss_cnt}, 32'd0);
        chk("t4_clear_valid", {31'b0, bus_if.drv_valid}, 32'd1);
        step();
        chk("t4_post_ub", {24'b0, underrun_b}, 32'd1);
        chk("t4_post_ua", {24'b0, underrun_a}, 32'd0);
        step();

        // Reset between the A and B words
        load(1'b1, 14'h3333, 1'b1, 14'h0444);
        wait_tick(n);
        step();
        step();
        chk("t5_a_data", {18'b0, bus_if.drv_data}, 32'h3333);
        chk("t5_a_valid", {31'b0, bus_if.drv_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", {31'b0, bus_if.drv_valid}, 32'd0);
        chk("t5_rst_data", {18'b0, bus_if.drv_data}, 32'd0);
        chk("t5_rst_b_rdy", {31'b0, bus_if.src_b_rdy}, 32'd1);
        chk("t5_rst_ua", {24'b0, underrun_a}, 32'd0);
        step();
        chk("t5_no_b_word", {31'b0, bus_if.drv_valid}, 32'd0);
        reset = 1'b0;
        wait_tick(n);
        chk("t5_tick_after_rst", n, 32'd125);
        expect_pair("t5", 14'h0000, 14'h0000);
        chk("t5_ua", {24'b0, underrun_a}, 32'd1);
        chk("t5_ub", {24'b0, underrun_b}, 32'd1);

        // Disable: in-flight pair completes, then silence for 1000 cycles
        load(1'b1, 14'h1111, 1'b1, 14'h0222);
        wait_tick(n);
        enable = 1'b0;
        expect_pair("t6", 14'h1111, 14'h0222);
        seen_tick  = 0;
        seen_valid = 0;
        repeat (1000) begin
            step();
            if (tick === 1'b1) seen_tick++;
            if (bus_if.drv_valid === 1'b1) seen_valid++;
        end
        chk("t6_no_tick", seen_tick, 32'd0);
        chk("t6_no_valid", seen_valid, 32'd0);
        enable = 1'b1;
        wait_tick(n);
        chk("t6_div_restart", n, 32'd125);
        expect_pair("t6r", 14'h1111, 14'h0222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
